// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory port arbiter slice.
//   DEF_ADDR_W / DEF_DATA_W : default memory address and data widths
//   OWN_NONE / OWN_IO / OWN_CACHE : owner encoding used by the read tag
//   arb_state_t : arbiter FSM states (same encoding as the owner values)
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IO    = 2'd1;
  localparam logic [1:0] OWN_CACHE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OWN_IO    = 2'd1,
    ST_OWN_CACHE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick between the IO requester and the cache requester.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (pointer returns to IO)
//   req_io     : IO request
//   req_cache  : cache request
//   lock_win   : cache burst lock is active, cache wins ties, pointer frozen
//   gnt_io     : IO granted this cycle (combinational)
//   gnt_cache  : cache granted this cycle (combinational)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_io,
  input  logic req_cache,
  input  logic lock_win,
  output logic gnt_io,
  output logic gnt_cache
);

  // 1 = cache wins the next tie, 0 = IO wins the next tie
  logic ptr_cache;

  // A lone requester always wins; ties are settled by the lock, then the pointer.
  always_comb begin
    gnt_io    = 1'b0;
    gnt_cache = 1'b0;
    if (req_io && req_cache) begin
      if (lock_win || ptr_cache) begin
        gnt_cache = 1'b1;
      end else begin
        gnt_io = 1'b1;
      end
    end else begin
      gnt_io    = req_io;
      gnt_cache = req_cache;
    end
  end

  // The pointer moves to the other requester after every grant, except while a
  // locked cache burst is holding ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_cache <= 1'b0;
    end else if (gnt_io) begin
      ptr_cache <= 1'b1;
    end else if (gnt_cache && !lock_win) begin
      ptr_cache <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares one BRAM port between the UART io_module and the processor cache.
// Ports:
//   clk_100, rst                  : clock, synchronous active-high reset
//   io_req/we/addr/wdata          : IO access request
//   io_gnt, io_rvalid, io_rdata   : IO accept strobe and read return
//   cache_req/we/lock/addr/wdata  : cache access request (lock holds a burst)
//   cache_gnt, cache_rvalid, cache_rdata : cache accept strobe and read return
//   mem_en/we/addr/wdata, mem_rdata : BRAM port (1-cycle read latency)
//   pro_stall                     : processor stall while cache waits for grant
// -----------------------------------------------------------------------------
module bram_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  input  logic              cache_req,
  input  logic              cache_we,
  input  logic              cache_lock,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic [DATA_W-1:0] cache_wdata,
  output logic              cache_gnt,
  output logic              cache_rvalid,
  output logic [DATA_W-1:0] cache_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pro_stall
);

  localparam int               CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  arb_state_t       state;
  logic [CNT_W-1:0] burst_cnt;
  logic             tag_valid;
  logic [1:0]       tag_owner;
  logic [DATA_W-1:0] io_rdata_q;
  logic [DATA_W-1:0] cache_rdata_q;
  logic             lock_win;

  // The lock only overrides ties while the cache already owns the port and
  // has not used up its burst allowance; deasserting lock acts immediately.
  assign lock_win = (state == ST_OWN_CACHE) && cache_lock && (burst_cnt < BURST_LIMIT);

  rr_arb2 u_arb (
    .clk       (clk_100),
    .rst       (rst),
    .req_io    (io_req),
    .req_cache (cache_req),
    .lock_win  (lock_win),
    .gnt_io    (io_gnt),
    .gnt_cache (cache_gnt)
  );

  // Port mux: the idle port parks on the IO address/data with enables low.
  always_comb begin
    mem_en    = io_gnt | cache_gnt;
    mem_we    = 1'b0;
    mem_addr  = io_addr;
    mem_wdata = io_wdata;
    if (cache_gnt) begin
      mem_we    = cache_we;
      mem_addr  = cache_addr;
      mem_wdata = cache_wdata;
    end else if (io_gnt) begin
      mem_we = io_we;
    end
  end

  assign pro_stall = cache_req && !cache_gnt;

  // Read returns come straight from the BRAM in the cycle after the grant.
  // Reset masks them immediately so an outstanding tag never surfaces.
  assign io_rvalid    = tag_valid && (tag_owner == OWN_IO) && !rst;
  assign cache_rvalid = tag_valid && (tag_owner == OWN_CACHE) && !rst;
  assign io_rdata     = io_rvalid ? mem_rdata : io_rdata_q;
  assign cache_rdata  = cache_rvalid ? mem_rdata : cache_rdata_q;

  // Ownership FSM, burst counter, read tag and the rdata hold registers.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state         <= ST_IDLE;
      burst_cnt     <= '0;
      tag_valid     <= 1'b0;
      tag_owner     <= OWN_NONE;
      io_rdata_q    <= '0;
      cache_rdata_q <= '0;
    end else begin
      if (io_gnt) begin
        state <= ST_OWN_IO;
      end else if (cache_gnt) begin
        state <= ST_OWN_CACHE;
      end else begin
        state <= ST_IDLE;
      end

      // Counter saturates so a long lone-cache burst still yields on the next tie.
      if (io_gnt || !cache_lock || !(io_req || cache_req)) begin
        burst_cnt <= '0;
      end else if (cache_gnt && (burst_cnt != BURST_LIMIT)) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end

      tag_valid <= (io_gnt && !io_we) || (cache_gnt && !cache_we);
      if (io_gnt) begin
        tag_owner <= OWN_IO;
      end else if (cache_gnt) begin
        tag_owner <= OWN_CACHE;
      end else begin
        tag_owner <= OWN_NONE;
      end

      if (io_rvalid) begin
        io_rdata_q <= mem_rdata;
      end
      if (cache_rvalid) begin
        cache_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a behavioural BRAM, a reference
// memory image and a scoreboard of expected read returns.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  logic        clk_100 = 1'b0;
  logic        rst;
  logic        io_req, io_we;
  logic [15:0] io_addr, io_wdata;
  logic        io_gnt, io_rvalid;
  logic [15:0] io_rdata;
  logic        cache_req, cache_we, cache_lock;
  logic [15:0] cache_addr, cache_wdata;
  logic        cache_gnt, cache_rvalid;
  logic [15:0] cache_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        pro_stall;

  typedef struct {
    logic        to_io;
    logic [15:0] data;
  } ret_t;

  ret_t        sb[$];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] bram [0:1023];
  logic        preloaded = 1'b0;
  logic [15:0] exp_io_hold;
  logic [15:0] exp_cache_hold;
  int          checks = 0;
  int          errors = 0;

  bram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(8)) dut (
    .clk_100      (clk_100),
    .rst          (rst),
    .io_req       (io_req),
    .io_we        (io_we),
    .io_addr      (io_addr),
    .io_wdata     (io_wdata),
    .io_gnt       (io_gnt),
    .io_rvalid    (io_rvalid),
    .io_rdata     (io_rdata),
    .cache_req    (cache_req),
    .cache_we     (cache_we),
    .cache_lock   (cache_lock),
    .cache_addr   (cache_addr),
    .cache_wdata  (cache_wdata),
    .cache_gnt    (cache_gnt),
    .cache_rvalid (cache_rvalid),
    .cache_rdata  (cache_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .pro_stall    (pro_stall)
  );

  always #5 clk_100 = ~clk_100;

  function automatic logic [15:0] initVal(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A00;
  endfunction

  // Behavioural BRAM: loads its image on the first edge, 1-cycle read latency.
  always @(posedge clk_100) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) bram[i] <= initVal(i);
      preloaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr[9:0]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ior, input logic iowe, input logic [15:0] ioa,
                               input logic [15:0] iowd, input logic cr, input logic cwe,
                               input logic cl, input logic [15:0] ca, input logic [15:0] cwd);
    io_req      = ior;
    io_we       = iowe;
    io_addr     = ioa;
    io_wdata    = iowd;
    cache_req   = cr;
    cache_we    = cwe;
    cache_lock  = cl;
    cache_addr  = ca;
    cache_wdata = cwd;
  endtask

  // Called at a falling edge with inputs applied: checks grants, the port mux,
  // the read return owed from the previous cycle, then books this cycle's access.
  task automatic stepCycle(input string tag, input logic eio, input logic ecache);
    ret_t r;
    #1;
    checkOutput({tag, "/io_gnt"}, io_gnt, eio);
    checkOutput({tag, "/cache_gnt"}, cache_gnt, ecache);
    checkOutput({tag, "/pro_stall"}, pro_stall, cache_req && !ecache);
    checkOutput({tag, "/mem_en"}, mem_en, eio | ecache);
    if (ecache) begin
      checkOutput({tag, "/mem_addr"}, mem_addr, cache_addr);
      checkOutput({tag, "/mem_we"}, mem_we, cache_we);
      if (cache_we) checkOutput({tag, "/mem_wdata"}, mem_wdata, cache_wdata);
    end else if (eio) begin
      checkOutput({tag, "/mem_addr"}, mem_addr, io_addr);
      checkOutput({tag, "/mem_we"}, mem_we, io_we);
    end else begin
      checkOutput({tag, "/mem_we_idle"}, mem_we, 1'b0);
      checkOutput({tag, "/mem_addr_idle"}, mem_addr, io_addr);
    end

    if (rst) begin
      checkOutput({tag, "/io_rvalid_rst"}, io_rvalid, 1'b0);
      checkOutput({tag, "/cache_rvalid_rst"}, cache_rvalid, 1'b0);
      sb.delete();
      exp_io_hold    = 16'h0000;
      exp_cache_hold = 16'h0000;
    end else if (sb.size() > 0) begin
      r = sb.pop_front();
      checkOutput({tag, "/io_rvalid"}, io_rvalid, r.to_io);
      checkOutput({tag, "/cache_rvalid"}, cache_rvalid, !r.to_io);
      if (r.to_io) begin
        checkOutput({tag, "/io_rdata"}, io_rdata, r.data);
        checkOutput({tag, "/cache_rdata_hold"}, cache_rdata, exp_cache_hold);
        exp_io_hold = r.data;
      end else begin
        checkOutput({tag, "/cache_rdata"}, cache_rdata, r.data);
        checkOutput({tag, "/io_rdata_hold"}, io_rdata, exp_io_hold);
        exp_cache_hold = r.data;
      end
    end else begin
      checkOutput({tag, "/io_rvalid_none"}, io_rvalid, 1'b0);
      checkOutput({tag, "/cache_rvalid_none"}, cache_rvalid, 1'b0);
      checkOutput({tag, "/io_rdata_hold"}, io_rdata, exp_io_hold);
      checkOutput({tag, "/cache_rdata_hold"}, cache_rdata, exp_cache_hold);
    end

    if (!rst) begin
      if (eio) begin
        if (io_we) ref_mem[io_addr[9:0]] = io_wdata;
        else       sb.push_back('{to_io: 1'b1, data: ref_mem[io_addr[9:0]]});
      end
      if (ecache) begin
        if (cache_we) ref_mem[cache_addr[9:0]] = cache_wdata;
        else          sb.push_back('{to_io: 1'b0, data: ref_mem[cache_addr[9:0]]});
      end
    end
    @(negedge clk_100);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("reset0", 0, 0);
    stepCycle("reset1", 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int cidx;
    for (int i = 0; i < 1024; i++) ref_mem[i] = initVal(i);
    exp_io_hold    = 16'h0000;
    exp_cache_hold = 16'h0000;
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk_100);
    resetDut();
    stepCycle("post_reset", 0, 0);

    $display("[TB] IO-only read of 0x0010");
    applyStimulus(1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("io_read", 1, 0);
    applyStimulus(0, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("io_read_ret", 0, 0);

    $display("[TB] alternating ties after reset");
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 0, 16'h0011, 16'h0, 1, 0, 0, 16'h0012, 16'h0);
      stepCycle($sformatf("alt%0d", k), (k % 2) == 0, (k % 2) == 1);
    end
    applyStimulus(0, 0, 16'h0011, 16'h0, 0, 0, 0, 16'h0012, 16'h0);
    stepCycle("alt_drain", 0, 0);
    stepCycle("alt_idle", 0, 0);

    $display("[TB] locked cache burst of 12 reads with IO waiting");
    cidx = 0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(i > 0, 0, 16'h0040, 16'h0, 1, 0, 1, 16'h0200 + 16'(cidx), 16'h0);
      stepCycle($sformatf("burst%0d", i), i == 8, i != 8);
      if (i != 8) cidx++;
    end
    applyStimulus(0, 0, 16'h0040, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("burst_drain", 0, 0);
    stepCycle("burst_idle", 0, 0);

    $display("[TB] cache write then IO read of 0x0020");
    applyStimulus(0, 0, 16'h0020, 16'h0, 1, 1, 0, 16'h0020, 16'h1234);
    stepCycle("cwrite", 0, 1);
    applyStimulus(1, 0, 16'h0020, 16'h0, 0, 0, 0, 16'h0020, 16'h0);
    stepCycle("io_after_write", 1, 0);
    applyStimulus(0, 0, 16'h0020, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("io_after_write_ret", 0, 0);

    $display("[TB] reset right after a granted cache read");
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h0033, 16'h0);
    stepCycle("pre_rst_read", 0, 1);
    rst = 1'b1;
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("mid_rst", 0, 0);
    rst = 1'b0;
    stepCycle("after_rst", 0, 0);
    applyStimulus(1, 0, 16'h0005, 16'h0, 1, 0, 0, 16'h0006, 16'h0);
    stepCycle("first_tie", 1, 0);
    applyStimulus(0, 0, 16'h0005, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("first_tie_ret", 0, 0);

    $display("[TB] back-to-back IO reads 0x0..0x3");
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1, 0, 16'(a), 16'h0, 0, 0, 0, 16'h0, 16'h0);
      stepCycle($sformatf("b2b%0d", a), 1, 0);
    end
    applyStimulus(0, 0, 16'h0003, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    stepCycle("b2b_drain", 0, 0);
    stepCycle("b2b_idle", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
